// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control path: opcodes, ALU op map, FSM states
// and operand-select codes, plus the instruction legality check.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_BEQ  = 5'b10000;
    localparam logic [4:0] ALU_BNE  = 5'b10001;
    localparam logic [4:0] ALU_BLT  = 5'b10100;
    localparam logic [4:0] ALU_BGE  = 5'b10101;
    localparam logic [4:0] ALU_BLTU = 5'b10110;
    localparam logic [4:0] ALU_BGEU = 5'b10111;

    localparam logic       SEL_A_RS1  = 1'b0;
    localparam logic       SEL_A_PC   = 1'b1;
    localparam logic [1:0] SEL_B_RS2  = 2'd0;
    localparam logic [1:0] SEL_B_IMM  = 2'd1;
    localparam logic [1:0] SEL_B_FOUR = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_CMP   = 3'd2,
        ST_PCUPD = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Shifts are not supported by this controller, nor are the reserved branch funct3 codes.
    function automatic logic insn_legal(input logic [31:0] w);
        logic ok;
        case (w[6:0])
            OPC_OP:     ok = ((w[31:25] == 7'b0000000) ||
                              ((w[31:25] == 7'b0100000) && (w[14:12] == 3'd0))) &&
                             (w[14:12] != 3'd1) && (w[14:12] != 3'd5);
            OPC_OPIMM:  ok = (w[14:12] != 3'd1) && (w[14:12] != 3'd5);
            OPC_BRANCH: ok = (w[14:12] != 3'd2) && (w[14:12] != 3'd3);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_ctrl_imm_gen.sv
// Combinational extraction of the sign-extended I-type and B-type immediates.
module imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] i_imm,
    output logic [31:0] b_imm
);

    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle RV32I control FSM driving the ALU op/operand-select stream,
// register-file write enable and PC write enable.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        alu_cmp,
    output logic [4:0]  alu_op,
    output logic        a_sel,
    output logic [1:0]  b_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic        pc_we,
    output logic        done,
    output logic        illegal
);

    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("RESET_PC must be word aligned");
    end

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        ready_q, ready_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic        a_sel_q, a_sel_d;
    logic [1:0]  b_sel_q, b_sel_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic        rd_we_q, rd_we_d, pc_we_q, pc_we_d, done_q, done_d, illegal_q, illegal_d;

    logic [31:0] word_s;
    logic [31:0] i_imm_s, b_imm_s;
    logic        alt_s;

    // In IDLE the incoming word is decoded so the first EXEC/CMP outputs are ready on entry.
    assign word_s = (state_q == ST_IDLE) ? instr : instr_q;
    assign alt_s  = (word_s[6:0] == OPC_OP) && (word_s[14:12] == 3'd0) && word_s[30];

    imm_gen u_imm_gen (
        .instr (word_s),
        .i_imm (i_imm_s),
        .b_imm (b_imm_s)
    );

    // Next-state and next-output computation; outputs are registered for the state being entered.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        ready_d   = 1'b0;
        alu_op_d  = ALU_ADD;
        a_sel_d   = SEL_A_RS1;
        b_sel_d   = SEL_B_RS2;
        imm_d     = 32'd0;
        rs1_d     = 5'd0;
        rs2_d     = 5'd0;
        rd_d      = 5'd0;
        rd_we_d   = 1'b0;
        pc_we_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!instr_valid) begin
                    ready_d = 1'b1;
                end else if (!insn_legal(word_s)) begin
                    instr_d   = instr;
                    state_d   = ST_ERR;
                    illegal_d = 1'b1;
                end else begin
                    instr_d = instr;
                    rs1_d   = word_s[19:15];
                    rs2_d   = word_s[24:20];
                    rd_d    = word_s[11:7];
                    if (word_s[6:0] == OPC_BRANCH) begin
                        state_d  = ST_CMP;
                        alu_op_d = {2'b10, word_s[14:12]};
                    end else begin
                        state_d  = ST_EXEC;
                        alu_op_d = {1'b0, alt_s, word_s[14:12]};
                        rd_we_d  = 1'b1;
                        if (word_s[6:0] == OPC_OPIMM) begin
                            b_sel_d = SEL_B_IMM;
                            imm_d   = i_imm_s;
                        end else begin
                            b_sel_d = SEL_B_RS2;
                        end
                    end
                end
            end
            ST_EXEC, ST_CMP: begin
                state_d = ST_PCUPD;
                rs1_d   = word_s[19:15];
                rs2_d   = word_s[24:20];
                rd_d    = word_s[11:7];
                a_sel_d = SEL_A_PC;
                pc_we_d = 1'b1;
                done_d  = 1'b1;
                // The sampled compare result lives on as the registered PC-update operand choice.
                if ((state_q == ST_CMP) && alu_cmp) begin
                    b_sel_d = SEL_B_IMM;
                    imm_d   = b_imm_s;
                end else begin
                    b_sel_d = SEL_B_FOUR;
                end
            end
            ST_PCUPD: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            ST_ERR: begin
                illegal_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State, latched instruction and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= 32'd0;
            ready_q   <= 1'b1;
            alu_op_q  <= ALU_ADD;
            a_sel_q   <= SEL_A_RS1;
            b_sel_q   <= SEL_B_RS2;
            imm_q     <= 32'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rd_q      <= 5'd0;
            rd_we_q   <= 1'b0;
            pc_we_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            ready_q   <= ready_d;
            alu_op_q  <= alu_op_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            imm_q     <= imm_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            pc_we_q   <= pc_we_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = ready_q;
    assign alu_op      = alu_op_q;
    assign a_sel       = a_sel_q;
    assign b_sel       = b_sel_q;
    assign imm         = imm_q;
    assign rs1_addr    = rs1_q;
    assign rs2_addr    = rs2_q;
    assign rd_addr     = rd_q;
    assign rd_we       = rd_we_q;
    assign pc_we       = pc_we_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed test-plan instructions followed by
// randomized instructions checked against a spec-level reference model.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        alu_cmp;
    logic [4:0]  alu_op;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, pc_we, done, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    alu_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_cmp(alu_cmp), .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel),
        .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rd_we(rd_we), .pc_we(pc_we), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_a_sel"}, 32'(a_sel), 32'd0);
        chk({tag, "_b_sel"}, 32'(b_sel), 32'd0);
        chk({tag, "_imm"}, imm, 32'd0);
        chk({tag, "_regs"}, 32'({rs1_addr, rs2_addr, rd_addr}), 32'd0);
        chk({tag, "_strobes"}, 32'({rd_we, pc_we, done}), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model: classify and predict outputs directly from the instruction fields.
    task automatic run_instr(input logic [31:0] w, input logic cmp, input string tag);
        int  opc, f3, f7, exp_op, b_off;
        bit  is_op, is_imm, is_br, legal;
        logic signed [31:0] i_off;
        opc    = int'(w[6:0]);
        f3     = int'(w[14:12]);
        f7     = int'(w[31:25]);
        is_op  = (opc == 51);
        is_imm = (opc == 19);
        is_br  = (opc == 99);
        legal  = (is_op && (f7 == 0 || (f7 == 32 && f3 == 0)) && f3 != 1 && f3 != 5) ||
                 (is_imm && f3 != 1 && f3 != 5) ||
                 (is_br && f3 != 2 && f3 != 3);
        i_off  = $signed(w) >>> 20;
        b_off  = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;

        chk({tag, "_ready_pre"}, 32'(instr_ready), 32'd1);
        instr = w;
        instr_valid = 1'b1;
        tick();
        instr = $urandom;
        instr_valid = 1'($urandom_range(0, 1));

        if (!legal) begin
            for (int i = 0; i < 3; i++) begin
                chk({tag, "_err_illegal"}, 32'(illegal), 32'd1);
                chk({tag, "_err_ready"}, 32'(instr_ready), 32'd0);
                chk({tag, "_err_strobes"}, 32'({rd_we, pc_we, done}), 32'd0);
                tick();
            end
            instr_valid = 1'b0;
            do_reset();
            check_idle({tag, "_post_err"});
            return;
        end

        chk({tag, "_p1_ready"}, 32'(instr_ready), 32'd0);
        chk({tag, "_p1_rs1"}, 32'(rs1_addr), 32'(w[19:15]));
        chk({tag, "_p1_rs2"}, 32'(rs2_addr), 32'(w[24:20]));
        chk({tag, "_p1_rd"}, 32'(rd_addr), 32'(w[11:7]));
        chk({tag, "_p1_a_sel"}, 32'(a_sel), 32'd0);
        chk({tag, "_p1_pc_done"}, 32'({pc_we, done, illegal}), 32'd0);
        if (is_br) begin
            chk({tag, "_cmp_op"}, 32'(alu_op), 32'(16 + f3));
            chk({tag, "_cmp_b_sel"}, 32'(b_sel), 32'd0);
            chk({tag, "_cmp_rd_we"}, 32'(rd_we), 32'd0);
            alu_cmp = cmp;
        end else begin
            exp_op = f3 + ((is_op && f3 == 0 && f7 == 32) ? 8 : 0);
            chk({tag, "_exec_op"}, 32'(alu_op), 32'(exp_op));
            chk({tag, "_exec_rd_we"}, 32'(rd_we), 32'd1);
            chk({tag, "_exec_b_sel"}, 32'(b_sel), is_imm ? 32'd1 : 32'd0);
            if (is_imm) begin
                chk({tag, "_exec_imm"}, imm, i_off);
            end
            alu_cmp = 1'($urandom_range(0, 1));
        end
        tick();
        alu_cmp = 1'($urandom_range(0, 1));

        chk({tag, "_pc_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_pc_a_sel"}, 32'(a_sel), 32'd1);
        chk({tag, "_pc_strobes"}, 32'({rd_we, pc_we, done}), 32'b011);
        chk({tag, "_pc_ready"}, 32'(instr_ready), 32'd0);
        if (is_br && cmp) begin
            chk({tag, "_pc_b_sel"}, 32'(b_sel), 32'd1);
            chk({tag, "_pc_imm"}, imm, 32'(b_off));
        end else begin
            chk({tag, "_pc_b_sel"}, 32'(b_sel), 32'd2);
        end
        instr_valid = 1'b0;
        tick();
        chk({tag, "_back_ready"}, 32'(instr_ready), 32'd1);
        chk({tag, "_back_strobes"}, 32'({rd_we, pc_we, done}), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        alu_cmp = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");
        tick();
        check_idle("idle_no_valid");

        run_instr(32'h002081B3, 1'b0, "add");
        run_instr(32'h402081B3, 1'b0, "sub");
        run_instr(32'hFFF00293, 1'b0, "addi");
        run_instr(32'h00208463, 1'b1, "beq_t");
        run_instr(32'h00208463, 1'b0, "beq_nt");
        run_instr(32'h00109093, 1'b0, "slli");

        // Reset asserted while a branch is in its compare cycle.
        instr = 32'h00208463;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("rst_cmp_op", 32'(alu_op), 32'h10);
        alu_cmp = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_async_strobes", 32'({rd_we, pc_we, done}), 32'd0);
        chk("rst_async_ready", 32'(instr_ready), 32'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_after_strobes", 32'({rd_we, pc_we, done}), 32'd0);
            chk("rst_after_ready", 32'(instr_ready), 32'd1);
        end
        run_instr(32'h002081B3, 1'b0, "add_after_rst");

        for (int n = 0; n < 200; n++) begin
            w = $urandom;
            case ($urandom_range(0, 5))
                0: w = {7'b0000000, w[24:0]};
                1: w = {7'b0100000, w[24:15], 3'b000, w[11:0]};
                default: ;
            endcase
            case ($urandom_range(0, 4))
                0, 1: w[6:0] = 7'b0110011;
                2: w[6:0] = 7'b0010011;
                3: w[6:0] = 7'b1100011;
                default: ;
            endcase
            run_instr(w, 1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
